// File: rtl/user_io_mc.sv
// user_io_mc: clk-domain decoder for the MCU user-I/O SPI channel.
// Oversamples SCK/SS/MOSI, decodes command + payload frames into joystick,
// mouse, keyboard and status outputs, and returns CORE_TYPE on MISO.
module user_io_mc #(
    parameter logic [7:0]  CORE_TYPE = 8'ha1,
    parameter int unsigned JOY_NUM   = 2,
    parameter int unsigned JOY_W     = 6,
    parameter int unsigned STATUS_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sck,
    input  logic                       spi_ss,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic                       spi_miso_oe,
    output logic [JOY_NUM*JOY_W-1:0]   joy,
    output logic [2:0]                 mouse_btn,
    output logic [7:0]                 kbd_mouse_data,
    output logic [1:0]                 kbd_mouse_type,
    output logic                       kbd_mouse_strobe,
    output logic [STATUS_W-1:0]        status
);

    localparam int unsigned JOY_BITS = JOY_NUM * JOY_W;

    localparam logic [7:0] CMD_MOUSE  = 8'h04;
    localparam logic [7:0] CMD_KBD    = 8'h05;
    localparam logic [7:0] CMD_STATUS = 8'h14;

    // Synchronizer chains; index 1 is the synchronized sample, index 2 the one before it.
    logic [2:0] sck_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;

    logic sck_rise, sck_fall, ss_s, ss_fall, mosi_s;

    // Frame/shift state and registered outputs.
    logic                active_q, active_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [6:0]          rx_q, rx_d;
    logic [7:0]          shift_q, shift_d;
    logic [JOY_BITS-1:0] joy_q, joy_d;
    logic [2:0]          btn_q, btn_d;
    logic [7:0]          data_q, data_d;
    logic [1:0]          type_q, type_d;
    logic                strobe_q, strobe_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [7:0]          byte_w;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_s     = ss_q[1];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign mosi_s   = mosi_q[1];
    assign byte_w   = {rx_q, mosi_s};

    // Bring the SPI pins into the clk domain; SS resets low so a frame in
    // progress at reset release never looks like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            ss_q   <= {ss_q[1:0], spi_ss};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            cmd_q      <= '0;
            rx_q       <= '0;
            shift_q    <= '0;
            joy_q      <= '0;
            btn_q      <= '0;
            data_q     <= '0;
            type_q     <= '0;
            strobe_q   <= 1'b0;
            status_q   <= '0;
        end else begin
            active_q   <= active_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            cmd_q      <= cmd_d;
            rx_q       <= rx_d;
            shift_q    <= shift_d;
            joy_q      <= joy_d;
            btn_q      <= btn_d;
            data_q     <= data_d;
            type_q     <= type_d;
            strobe_q   <= strobe_d;
            status_q   <= status_d;
        end
    end

    // Frame tracking, shifting and payload decode.
    always_comb begin
        active_d   = active_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        cmd_d      = cmd_q;
        rx_d       = rx_q;
        shift_d    = shift_q;
        joy_d      = joy_q;
        btn_d      = btn_q;
        data_d     = data_q;
        type_d     = type_q;
        strobe_d   = 1'b0;
        status_d   = status_q;

        if (ss_s) begin
            // Deselected: drop any partial byte, outputs hold.
            active_d   = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            cmd_d      = '0;
        end else if (ss_fall) begin
            active_d   = 1'b1;
            shift_d    = CORE_TYPE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (active_q) begin
            if (sck_fall) begin
                shift_d = {shift_q[6:0], 1'b0};
            end
            if (sck_rise) begin
                rx_d      = byte_w[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q == 3'd0) begin
                        cmd_d      = byte_w;
                        byte_cnt_d = 3'd1;
                    end else begin
                        if (byte_cnt_q != 3'd4) begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                        if (cmd_q[7:2] == 6'b000100 && byte_cnt_q == 3'd1) begin
                            // Out-of-range joystick numbers match no slice.
                            for (int unsigned i = 0; i < JOY_NUM; i++) begin
                                if (cmd_q[1:0] == 2'(i)) begin
                                    joy_d[i*JOY_W +: JOY_W] = byte_w[JOY_W-1:0];
                                end
                            end
                        end else if (cmd_q == CMD_MOUSE) begin
                            if (byte_cnt_q == 3'd1 || byte_cnt_q == 3'd2) begin
                                strobe_d = 1'b1;
                                data_d   = byte_w;
                                type_d   = (byte_cnt_q == 3'd1) ? 2'd0 : 2'd1;
                            end else if (byte_cnt_q == 3'd3) begin
                                btn_d = byte_w[2:0];
                            end
                        end else if (cmd_q == CMD_KBD) begin
                            strobe_d = 1'b1;
                            data_d   = byte_w;
                            type_d   = 2'd2;
                        end else if (cmd_q == CMD_STATUS && byte_cnt_q == 3'd1) begin
                            status_d = byte_w[STATUS_W-1:0];
                        end
                    end
                end
            end
        end
    end

    assign spi_miso         = shift_q[7];
    assign spi_miso_oe      = active_q;
    assign joy              = joy_q;
    assign mouse_btn        = btn_q;
    assign kbd_mouse_data   = data_q;
    assign kbd_mouse_type   = type_q;
    assign kbd_mouse_strobe = strobe_q;
    assign status           = status_q;

endmodule

// File: tb/tb_user_io_mc.sv
// Bench for user_io_mc: default build (a) and a JOY_NUM=4/JOY_W=8 build (b)
// share one SPI bus; strobes from (a) are scored against an expected queue.
module tb_user_io_mc;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst;
    logic spi_sck, spi_ss, spi_mosi;

    logic        miso_a, oe_a, strobe_a;
    logic [11:0] joy_a;
    logic [2:0]  btn_a;
    logic [7:0]  data_a;
    logic [1:0]  type_a;
    logic [7:0]  status_a;

    logic        miso_b, oe_b, strobe_b;
    logic [31:0] joy_b;
    logic [2:0]  btn_b;
    logic [7:0]  data_b;
    logic [1:0]  type_b;
    logic [7:0]  status_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe = -1000;
    logic prev_strobe = 1'b0;

    logic [9:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] miso_byte;

    always #5 clk = ~clk;

    user_io_mc u_dut_a (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .joy(joy_a), .mouse_btn(btn_a),
        .kbd_mouse_data(data_a), .kbd_mouse_type(type_a), .kbd_mouse_strobe(strobe_a),
        .status(status_a)
    );

    user_io_mc #(.JOY_NUM(4), .JOY_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .joy(joy_b), .mouse_btn(btn_b),
        .kbd_mouse_data(data_b), .kbd_mouse_type(type_b), .kbd_mouse_strobe(strobe_b),
        .status(status_b)
    );

    // One clk step; scores any strobe from the default build as it appears.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (strobe_a) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected got data=%h type=%0d want no strobe", data_a, type_a);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({data_a, type_a} !== e) begin
                    failures++;
                    $display("FAIL strobe_event got data=%h type=%0d want data=%h type=%0d",
                             data_a, type_a, e[9:2], e[1:0]);
                end
            end
            checks++;
            if (prev_strobe || (cyc - last_strobe) < 16) begin
                failures++;
                $display("FAIL strobe_spacing got gap=%0d prev=%b want gap>=16 prev=0",
                         cyc - last_strobe, prev_strobe);
            end
            last_strobe = cyc;
        end
        prev_strobe = strobe_a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    // Shift nbits of v MSB first; returns MISO sampled just before each rising edge.
    task automatic send_byte(input logic [7:0] v, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = v[7-i];
            repeat (HALF) tick();
            rx[7-i] = miso_a;
            spi_sck = 1'b1;
            repeat (HALF) tick();
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_ss = 1'b0;
        repeat (6) tick();
    endtask

    task automatic frame_end();
        repeat (HALF) tick();
        spi_ss = 1'b1;
        repeat (8) tick();
    endtask

    // Send every byte in tx_q as one frame; MISO of byte 0 lands in miso_byte.
    task automatic send_frame();
        logic [7:0] rx;
        bit first = 1'b1;
        frame_begin();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front(), 8, rx);
            if (first) miso_byte = rx;
            first = 1'b0;
        end
        frame_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({miso_a, oe_a, joy_a, btn_a, status_a} !== '0) begin
            failures++;
            $display("FAIL reset_outs got miso=%b oe=%b joy=%h btn=%b status=%h want all 0",
                     miso_a, oe_a, joy_a, btn_a, status_a);
        end
        checks++;
        if ({data_a, type_a, strobe_a, joy_b} !== '0) begin
            failures++;
            $display("FAIL reset_events got data=%h type=%0d strobe=%b joy_b=%h want all 0",
                     data_a, type_a, strobe_a, joy_b);
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_joy4();
        do_reset();
        tx_q = '{8'h13, 8'h81};
        send_frame();
        tx_q = '{8'h15, 8'hFF};
        send_frame();
        checks++;
        if (joy_b !== 32'h8100_0000) begin
            failures++;
            $display("FAIL joy4_slices got %h want 81000000", joy_b);
        end
        checks++;
        if (joy_a !== 12'h000) begin
            failures++;
            $display("FAIL joy2_out_of_range got %h want 000", joy_a);
        end
    endtask

    task automatic test_joy();
        logic [7:0] rx;
        frame_begin();
        checks++;
        if (oe_a !== 1'b1) begin
            failures++;
            $display("FAIL oe_in_frame got %b want 1", oe_a);
        end
        send_byte(8'h11, 8, rx);
        checks++;
        if (rx !== 8'hA1) begin
            failures++;
            $display("FAIL miso_core_type got %h want a1", rx);
        end
        send_byte(8'hFF, 8, rx);
        checks++;
        if (rx !== 8'h00) begin
            failures++;
            $display("FAIL miso_after_cmd got %h want 00", rx);
        end
        frame_end();
        checks++;
        if (joy_a !== 12'hFC0 || oe_a !== 1'b0) begin
            failures++;
            $display("FAIL joy_frame got joy=%h oe=%b want joy=fc0 oe=0", joy_a, oe_a);
        end
    endtask

    task automatic test_mouse();
        int s0 = strobe_cnt;
        tx_q = '{8'h04, 8'h05, 8'hFB, 8'h03};
        exp_q.push_back({8'h05, 2'd0});
        exp_q.push_back({8'hFB, 2'd1});
        send_frame();
        checks++;
        if (strobe_cnt - s0 !== 2 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL mouse_strobes got %0d pending=%0d want 2 pending=0", strobe_cnt - s0, exp_q.size());
        end
        checks++;
        if (btn_a !== 3'b011 || data_a !== 8'hFB || type_a !== 2'd1) begin
            failures++;
            $display("FAIL mouse_hold got btn=%b data=%h type=%0d want btn=011 data=fb type=1",
                     btn_a, data_a, type_a);
        end
    endtask

    task automatic test_keyboard();
        int s0 = strobe_cnt;
        tx_q = '{8'h05, 8'h45, 8'hC5, 8'h12};
        exp_q.push_back({8'h45, 2'd2});
        exp_q.push_back({8'hC5, 2'd2});
        exp_q.push_back({8'h12, 2'd2});
        send_frame();
        checks++;
        if (strobe_cnt - s0 !== 3 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL kbd_strobes got %0d pending=%0d want 3 pending=0", strobe_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        frame_begin();
        send_byte(8'h14, 8, rx);
        send_byte(8'hAA, 5, rx);
        frame_end();
        checks++;
        if (status_a !== 8'h00) begin
            failures++;
            $display("FAIL partial_status got %h want 00", status_a);
        end
        tx_q = '{8'h14, 8'h5A};
        send_frame();
        checks++;
        if (status_a !== 8'h5A) begin
            failures++;
            $display("FAIL status_frame got %h want 5a", status_a);
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] rx;
        frame_begin();
        send_byte(8'h10, 8, rx);
        send_byte(8'h3F, 4, rx);
        rst = 1'b1;
        tick();
        checks++;
        if (joy_a !== 12'h000 || oe_a !== 1'b0 || status_a !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid got joy=%h oe=%b status=%h want 000 0 00", joy_a, oe_a, status_a);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        // Rest of the byte plus another full "frame" without a fresh SS edge.
        send_byte(8'hF0, 4, rx);
        send_byte(8'h10, 8, rx);
        send_byte(8'h2A, 8, rx);
        frame_end();
        checks++;
        if (joy_a !== 12'h000) begin
            failures++;
            $display("FAIL rst_no_fresh_ss got joy=%h want 000", joy_a);
        end
        tx_q = '{8'h10, 8'h3F};
        send_frame();
        checks++;
        if (joy_a !== 12'h03F) begin
            failures++;
            $display("FAIL joy_after_rst got %h want 03f", joy_a);
        end
    endtask

    task automatic test_back_to_back();
        int s0 = strobe_cnt;
        tx_q = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 1; i <= 6; i++) exp_q.push_back({8'(i), 2'd2});
        send_frame();
        checks++;
        if (strobe_cnt - s0 !== 6 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL kbd_long_frame got %0d pending=%0d want 6 pending=0", strobe_cnt - s0, exp_q.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        miso_byte = '0;
        test_reset();
        test_joy4();
        test_joy();
        test_mouse();
        test_keyboard();
        test_partial();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
